quadrant_selector: RTL and testbench
====================================

# quadrant_selector

Cursor/selection controller for the VGA quadrant highlighter. It turns debounced player buttons and the per-frame tick into the 3-bit quadrant code consumed by the highlight comparator, and blinks the cursor at a frame-based rate. It also commits selections with a frame-timed lockout and blanks the highlight once the game reports a win. It sits between the button debouncers / frame timing generator and the comparator's quadrant-select input.

## Interface
- BLINK_FRAMES, 30, frame ticks per blink half-period (≥1)
- LOCK_FRAMES, 60, frame ticks the committed quadrant is held steady after a selection (≥1)
- clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- btn_next  in  1  debounced, synchronized level; rising edge advances the cursor
- btn_prev  in  1  debounced, synchronized level; rising edge moves the cursor back
- btn_sel  in  1  debounced, synchronized level; rising edge commits the cursor
- win  in  1  level; game won
- cuadrante  out  3  quadrant code to comparator: 3'b000 = none, 3'b001..3'b100 = quadrant 1..4
- sel_valid  out  1  one-cycle pulse when a selection is committed
- sel_quad  out  3  last committed quadrant, held until next commit
- busy  out  1  high while in LOCK

## Operation
- All outputs registered. Reset values: cuadrante=000, sel_valid=0, sel_quad=000, busy=0; state=IDLE, cursor=001, blink=1, frame counter=0.
- Edge detect: per-button previous-level register, reset to 1, so a button held through reset produces no edge until released and re-pressed. Edge = level & ~prev.
- Priority of same-cycle edges: win > sel > next/prev. next and prev together with no sel: no move.
- IDLE: cuadrante=000. Any button edge goes to ACTIVE with cursor=001, blink=1, counter=0. That first edge does not move or commit.
- ACTIVE: cuadrante = blink ? cursor : 000.
  - next: cursor 001→010→011→100→001 (wrap).
  - prev: cursor 100→011→010→001→100 (wrap).
  - Any move sets blink=1 and counter=0.
  - frame_tick with no button edge: counter+1. When counter == BLINK_FRAMES-1, blink toggles and counter=0.
  - sel: go to LOCK; sel_valid=1 for one cycle; sel_quad=cursor; counter=0; busy=1.
- LOCK: cuadrante=cursor steady (no blink). All button edges are ignored and discarded, not queued. Each frame_tick increments the counter. The LOCK_FRAMES-th tick returns to ACTIVE with blink=1, counter=0, busy=0.
- DONE: entered from any state on the cycle win is sampled 1. In DONE: cuadrante=000, busy=0, sel_valid=0, sel_quad holds. DONE is sticky until rst; win falling has no effect.
- Counter width: clog2(max(BLINK_FRAMES, LOCK_FRAMES)+1). It must not overflow for any parameter value ≥1.

## Timing
- Button edge sampled at clock edge k (level 1 at k, 0 at k-1): cuadrante, sel_valid, sel_quad and busy reflect it after edge k (single registered stage).
- sel_valid is high exactly one cycle. It never asserts in LOCK, IDLE or DONE.
- Button edge coincident with frame_tick in ACTIVE: the button action wins and the tick is dropped (counter cleared).
- frame_tick coincident with sel in ACTIVE: LOCK starts with counter=0, and that tick is not counted.
- rst asserted mid-LOCK or mid-blink: all state returns to reset values after the edge sampling rst=1. This takes priority over win and buttons.
- win and sel on the same edge: go to DONE, no sel_valid, sel_quad unchanged.

## Test plan
Run with BLINK_FRAMES=2 and LOCK_FRAMES=3.
- Reset, then press btn_next → cuadrante goes 000→001 (IDLE→ACTIVE). Four more btn_next edges → 010, 011, 100, 001 (wrap). One btn_prev → 100.
- ACTIVE with cursor 010, no buttons, frame_tick every 10 cycles → cuadrante 010 for 2 ticks, 000 for 2 ticks, 010 again. A btn_next during the 000 phase → immediately 011 with blink restarted.
- btn_sel at cursor 011 → sel_valid=1 for exactly 1 cycle, sel_quad=011, busy=1. btn_next edges during lock change nothing. After the 3rd frame_tick, busy=0 and blinking resumes at 011.
- btn_sel held high through rst deassert → no selection and no IDLE exit. Release and re-press → ACTIVE with cuadrante=001.
- win and btn_sel rising on the same edge in ACTIVE → cuadrante=000, sel_valid stays 0. win then drops and buttons are pressed → cuadrante stays 000 until rst.
- rst pulsed in LOCK after 1 frame_tick → all outputs at reset values the next cycle. The next button edge re-enters ACTIVE at 001.

Source files
------------

// File: rtl/quadrant_selector.sv
// ----------------------------------------------------------------------------
// quadrant_selector
//   Cursor/selection controller for the VGA quadrant highlighter. Turns
//   debounced buttons and the per-frame tick into the 3-bit quadrant code for
//   the highlight comparator, blinks the cursor at a frame-based rate, commits
//   selections with a frame-timed lockout and blanks the highlight after a win.
//
// Parameters
//   BLINK_FRAMES : frame ticks per blink half-period (>= 1)
//   LOCK_FRAMES  : frame ticks the committed quadrant is held after a select (>= 1)
//
// Ports
//   clk        in   pixel clock, rising edge
//   rst        in   synchronous active-high reset
//   frame_tick in   one-cycle pulse per video frame
//   btn_next   in   debounced level, rising edge advances the cursor
//   btn_prev   in   debounced level, rising edge moves the cursor back
//   btn_sel    in   debounced level, rising edge commits the cursor
//   win        in   level, game won (sticky blanking until reset)
//   cuadrante  out  3'b000 = none, 3'b001..3'b100 = quadrant 1..4
//   sel_valid  out  one-cycle pulse on a committed selection
//   sel_quad   out  last committed quadrant
//   busy       out  high while the selection lockout is running
// ----------------------------------------------------------------------------
module quadrant_selector #(
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned LOCK_FRAMES  = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_sel,
    input  logic       win,
    output logic [2:0] cuadrante,
    output logic       sel_valid,
    output logic [2:0] sel_quad,
    output logic       busy
);

    // Counter is shared by blink and lock timing, sized for the larger of the two.
    localparam int unsigned CNT_MAX = (BLINK_FRAMES > LOCK_FRAMES) ? BLINK_FRAMES : LOCK_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [2:0] QUAD_NONE  = 3'd0;
    localparam logic [2:0] QUAD_FIRST = 3'd1;
    localparam logic [2:0] QUAD_LAST  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_LOCK   = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic             next_prev_q, prev_prev_q, sel_prev_q;
    logic [2:0]       cursor_q, cursor_d;
    logic             blink_q, blink_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       cuadrante_q, cuadrante_d;
    logic             sel_valid_q, sel_valid_d;
    logic [2:0]       sel_quad_q, sel_quad_d;
    logic             busy_q, busy_d;

    logic next_edge, prev_edge, sel_edge, any_edge;

    // Rising-edge detection; previous levels reset to 1 so a held button is ignored.
    assign next_edge = btn_next & ~next_prev_q;
    assign prev_edge = btn_prev & ~prev_prev_q;
    assign sel_edge  = btn_sel  & ~sel_prev_q;
    assign any_edge  = next_edge | prev_edge | sel_edge;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: win overrides everything, DONE is sticky.
    always_comb begin
        state_d = state_q;
        if (win) begin
            state_d = S_DONE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (any_edge) begin
                        state_d = S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (sel_edge) begin
                        state_d = S_LOCK;
                    end
                end
                S_LOCK: begin
                    if (frame_tick && (cnt_q == LOCK_LAST)) begin
                        state_d = S_ACTIVE;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Datapath and output next-values.
    always_comb begin
        cursor_d    = cursor_q;
        blink_d     = blink_q;
        cnt_d       = cnt_q;
        sel_valid_d = 1'b0;
        sel_quad_d  = sel_quad_q;

        if (!win) begin
            unique case (state_q)
                S_IDLE: begin
                    // Wake-up edge only activates; it neither moves nor commits.
                    if (any_edge) begin
                        cursor_d = QUAD_FIRST;
                        blink_d  = 1'b1;
                        cnt_d    = '0;
                    end
                end
                S_ACTIVE: begin
                    if (sel_edge) begin
                        sel_valid_d = 1'b1;
                        sel_quad_d  = cursor_q;
                        cnt_d       = '0;
                    end else if (next_edge && !prev_edge) begin
                        cursor_d = (cursor_q == QUAD_LAST) ? QUAD_FIRST : cursor_q + 3'd1;
                        blink_d  = 1'b1;
                        cnt_d    = '0;
                    end else if (prev_edge && !next_edge) begin
                        cursor_d = (cursor_q == QUAD_FIRST) ? QUAD_LAST : cursor_q - 3'd1;
                        blink_d  = 1'b1;
                        cnt_d    = '0;
                    end else if (next_edge && prev_edge) begin
                        // Conflicting moves cancel; a coincident tick is still dropped.
                        cnt_d = '0;
                    end else if (frame_tick) begin
                        if (cnt_q == BLINK_LAST) begin
                            blink_d = ~blink_q;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                S_LOCK: begin
                    // Button edges are discarded here; only frame ticks advance.
                    if (frame_tick) begin
                        if (cnt_q == LOCK_LAST) begin
                            blink_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                S_DONE: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end

        // Outputs reflect the state being entered so they appear one edge after the cause.
        unique case (state_d)
            S_ACTIVE: cuadrante_d = blink_d ? cursor_d : QUAD_NONE;
            S_LOCK:   cuadrante_d = cursor_d;
            default:  cuadrante_d = QUAD_NONE;
        endcase
        busy_d = (state_d == S_LOCK);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            next_prev_q <= 1'b1;
            prev_prev_q <= 1'b1;
            sel_prev_q  <= 1'b1;
            cursor_q    <= QUAD_FIRST;
            blink_q     <= 1'b1;
            cnt_q       <= '0;
            cuadrante_q <= QUAD_NONE;
            sel_valid_q <= 1'b0;
            sel_quad_q  <= QUAD_NONE;
            busy_q      <= 1'b0;
        end else begin
            next_prev_q <= btn_next;
            prev_prev_q <= btn_prev;
            sel_prev_q  <= btn_sel;
            cursor_q    <= cursor_d;
            blink_q     <= blink_d;
            cnt_q       <= cnt_d;
            cuadrante_q <= cuadrante_d;
            sel_valid_q <= sel_valid_d;
            sel_quad_q  <= sel_quad_d;
            busy_q      <= busy_d;
        end
    end

    assign cuadrante = cuadrante_q;
    assign sel_valid = sel_valid_q;
    assign sel_quad  = sel_quad_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_quadrant_selector.sv
// ----------------------------------------------------------------------------
// tb_quadrant_selector
//   Directed scenarios followed by randomized stimulus, all outputs compared
//   every cycle against a behavioural model of the quadrant selector.
// ----------------------------------------------------------------------------
module tb_quadrant_selector;

    localparam int unsigned BF = 2;
    localparam int unsigned LF = 3;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_sel;
    logic       win;
    logic [2:0] cuadrante;
    logic       sel_valid;
    logic [2:0] sel_quad;
    logic       busy;

    int n_chk;
    int n_bad;

    quadrant_selector #(
        .BLINK_FRAMES(BF),
        .LOCK_FRAMES (LF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .btn_next  (btn_next),
        .btn_prev  (btn_prev),
        .btn_sel   (btn_sel),
        .win       (win),
        .cuadrante (cuadrante),
        .sel_valid (sel_valid),
        .sel_quad  (sel_quad),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: mode 0 idle, 1 active, 2 lock, 3 done.
    int m_mode, m_cur, m_cnt;
    bit m_blink, m_ln, m_lp, m_ls;
    int m_cq, m_sq;
    bit m_sv, m_busy;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit t, input bit n, input bit p,
                              input bit s, input bit w);
        bit en, ep, es;
        if (r) begin
            m_mode = 0; m_cur = 1; m_blink = 1; m_cnt = 0;
            m_ln = 1; m_lp = 1; m_ls = 1;
            m_sv = 0; m_sq = 0;
        end else begin
            en = n && !m_ln;
            ep = p && !m_lp;
            es = s && !m_ls;
            m_ln = n; m_lp = p; m_ls = s;
            m_sv = 0;
            if (w) begin
                m_mode = 3;
            end else if (m_mode == 0) begin
                if (en || ep || es) begin
                    m_mode = 1; m_cur = 1; m_blink = 1; m_cnt = 0;
                end
            end else if (m_mode == 1) begin
                if (es) begin
                    m_mode = 2; m_sv = 1; m_sq = m_cur; m_cnt = 0;
                end else if (en || ep) begin
                    if (en && !ep) m_cur = m_cur % 4 + 1;
                    if (ep && !en) m_cur = (m_cur + 2) % 4 + 1;
                    if (en != ep) m_blink = 1;
                    m_cnt = 0;
                end else if (t) begin
                    m_cnt++;
                    if (m_cnt == BF) begin
                        m_blink = !m_blink;
                        m_cnt = 0;
                    end
                end
            end else if (m_mode == 2) begin
                if (t) begin
                    m_cnt++;
                    if (m_cnt == LF) begin
                        m_mode = 1; m_blink = 1; m_cnt = 0;
                    end
                end
            end
        end
        m_cq   = (m_mode == 1) ? (m_blink ? m_cur : 0) : ((m_mode == 2) ? m_cur : 0);
        m_busy = (m_mode == 2);
    endtask

    // One clock with the given inputs, then compare every output to the model.
    task automatic cyc(input bit r, input bit t, input bit n, input bit p,
                       input bit s, input bit w);
        rst = r; frame_tick = t; btn_next = n; btn_prev = p; btn_sel = s; win = w;
        @(posedge clk);
        model_step(r, t, n, p, s, w);
        #1;
        chk("cuadrante", 8'(cuadrante), 8'(m_cq));
        chk("sel_valid", 8'(sel_valid), 8'(m_sv));
        chk("sel_quad",  8'(sel_quad),  8'(m_sq));
        chk("busy",      8'(busy),      8'(m_busy));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic press_next();
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit rn, rp, rs, rw, rt, rr;
        int k;
        n_chk = 0;
        n_bad = 0;
        rst = 1'b1; frame_tick = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
        btn_sel = 1'b0; win = 1'b0;

        // Reset values
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_cuadrante", 8'(cuadrante), 8'd0);
        chk("rst_sel_quad",  8'(sel_quad),  8'd0);
        chk("rst_busy",      8'(busy),      8'd0);
        idle(2);

        // Wake-up and cursor wrap
        cyc(0, 0, 1, 0, 0, 0);
        chk("wake_001", 8'(cuadrante), 8'd1);
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) press_next();
        chk("wrap_001", 8'(cuadrante), 8'd1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("prev_100", 8'(cuadrante), 8'd4);
        cyc(0, 0, 0, 0, 0, 0);
        press_next();
        press_next();
        chk("at_010", 8'(cuadrante), 8'd2);

        // Blink with ticks every 10 cycles, then a move during the dark phase
        for (int f = 0; f < 3; f++) begin
            idle(9);
            cyc(0, 1, 0, 0, 0, 0);
        end
        chk("blink_dark", 8'(cuadrante), 8'd0);
        press_next();
        chk("move_relight", 8'(cuadrante), 8'd3);
        for (int f = 0; f < 4; f++) begin
            idle(9);
            cyc(0, 1, 0, 0, 0, 0);
        end
        chk("blink_back", 8'(cuadrante), 8'd3);

        // Commit at 011, lockout ignores next, resumes after 3rd tick
        cyc(0, 0, 0, 0, 1, 0);
        chk("sel_pulse", 8'(sel_valid), 8'd1);
        chk("sel_quad_011", 8'(sel_quad), 8'd3);
        chk("lock_busy", 8'(busy), 8'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("sel_one_cycle", 8'(sel_valid), 8'd0);
        press_next();
        cyc(0, 1, 0, 0, 0, 0);
        press_next();
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("lock_steady", 8'(cuadrante), 8'd3);
        cyc(0, 1, 0, 0, 0, 0);
        chk("lock_release", 8'(busy), 8'd0);
        idle(25);

        // Select held through reset does nothing until re-pressed
        cyc(1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("held_no_exit", 8'(cuadrante), 8'd0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("repress_001", 8'(cuadrante), 8'd1);
        chk("repress_no_sel", 8'(sel_valid), 8'd0);
        cyc(0, 0, 0, 0, 0, 0);

        // Win beats select, DONE is sticky
        cyc(0, 0, 0, 0, 1, 1);
        chk("win_blank", 8'(cuadrante), 8'd0);
        chk("win_no_sel", 8'(sel_valid), 8'd0);
        cyc(0, 0, 0, 0, 0, 0);
        press_next();
        cyc(0, 1, 0, 0, 1, 0);
        chk("done_sticky", 8'(cuadrante), 8'd0);
        cyc(0, 0, 0, 0, 0, 0);

        // Reset in the middle of a lockout
        cyc(1, 0, 0, 0, 0, 0);
        press_next();
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("midlock_rst_busy", 8'(busy), 8'd0);
        chk("midlock_rst_quad", 8'(sel_quad), 8'd0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("after_rst_001", 8'(cuadrante), 8'd1);

        // Randomized: at most one button toggles per cycle
        rn = 1; rp = 0; rs = 0;
        for (int i = 0; i < 4000; i++) begin
            rr = ($urandom_range(0, 249) == 0);
            rw = ($urandom_range(0, 399) == 0);
            rt = ($urandom_range(0, 3) == 0);
            k  = $urandom_range(0, 7);
            if (k == 0) rn = !rn;
            else if (k == 1) rp = !rp;
            else if (k == 2 && $urandom_range(0, 1) == 0) rs = !rs;
            cyc(rr, rt, rn, rp, rs, rw);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
